imem_fetch_responder: RTL and testbench
=======================================

// Module: imem_fetch_responder
// PURPOSE
//  Responder side of the instruction-fetch interface: accepts byte-addressed PC fetch requests from the
//  IF stage and returns 32-bit instruction words over a valid/ready handshake.
//  Models a pipelined instruction ROM with fixed read latency, a credit-limited response buffer and
//  flush on redirect (branch taken / PC reload). Sits between the fetch stage and the program image.
// PARAMETERS
//  MEM_WORDS   1024                 number of 32-bit words in the ROM (power of two)
//  LATENCY     2                    request-accept to earliest resp_valid, in cycles (legal 1..4)
//  FIFO_DEPTH  4                    max in-flight + buffered responses (power of two, >= LATENCY)
//  INIT_FILE   "instructions.mem"   hex image loaded into the ROM at elaboration
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst         in   1   reset, asynchronous, active-low
//  req_valid   in   1   fetch request present
//  req_ready   out  1   responder can accept a request this cycle
//  req_addr    in   64  byte address (PC) of requested instruction
//  flush       in   1   discard all in-flight and buffered responses
//  resp_valid  out  1   response word present
//  resp_ready  in   1   fetch stage consumes response this cycle
//  resp_instr  out  32  instruction word
//  resp_addr   out  64  address the response belongs to
//  resp_err    out  1   address fault (out of range; misaligned when checking is enabled)
// BEHAVIOUR
//  - Reset (rst low, async): req_ready=0 while asserted, then 1 the first cycle after release;
//    resp_valid=0, resp_instr=0, resp_addr=0, resp_err=0; pipeline valids and FIFO pointers cleared.
//    Reset mid-operation drops every outstanding request; no response is ever produced for it.
//  - Accept: req_valid && req_ready on a rising edge. Word index = req_addr[log2(MEM_WORDS)+1:2].
//  - Latency: accepted request at edge N appears at FIFO head no earlier than edge N+LATENCY;
//    resp_valid rises in that cycle if FIFO was empty. Fully pipelined: one accept per cycle.
//  - Credits: count = in-flight (pipeline) + FIFO occupancy; req_ready = (count < FIFO_DEPTH).
//    Response pipeline never stalls; credit guarantees FIFO never overflows.
//  - Simultaneous accept and pop in one cycle: count unchanged. Pointers wrap modulo FIFO_DEPTH.
//  - Output handshake: resp_* held stable while resp_valid && !resp_ready; pop on resp_valid && resp_ready.
//    Responses returned strictly in request order.
//  - Range: req_addr >= 4*MEM_WORDS -> resp_instr=32'h0000_0013 (NOP), resp_err=1.
//  - Flush (synchronous, one cycle): clears pipeline valids and FIFO; resp_valid=0 next cycle;
//    count=0 next cycle. A request presented in the flush cycle IS accepted (redirected PC) and
//    is the first response after flush. Flush has priority over a same-cycle pop.
//  - No state machine beyond pipeline shift register + FIFO; outputs are FIFO head, registered.
// CONFIGURATION
//  IMEM_ALIGN_CHECK_EN defined: req_addr[1:0]!=0 -> resp_instr=NOP, resp_err=1 (combined with range).
//  Not defined: req_addr[1:0] ignored, misaligned address reads the enclosing word, resp_err range-only.
// STRUCTURE
//  Package imem_pkg: NOP_INSTR=32'h0000_0013, typedef imem_resp_t {addr[63:0], instr[31:0], err},
//    clog2-derived index/count width constants.
//  Sub-module imem_resp_fifo: FIFO_DEPTH-entry synchronous FIFO of imem_resp_t with push/pop/clear,
//    count output. Top holds ROM array, LATENCY-deep valid/addr/data pipeline, credit logic.
// TESTING
//  1. Image words 0..3 = 11,22,33,44; req 0x0,0x4,0x8,0xC back-to-back, resp_ready=1 -> resp_valid
//     from cycle 2 after first accept, instr 11,22,33,44 in order, one per cycle, resp_err=0.
//  2. resp_ready=0, continuous requests -> exactly 4 accepted then req_ready=0; release resp_ready ->
//     4 responses in order, req_ready returns 1 the cycle after first pop.
//  3. 3 requests in flight, flush with req 0x40 same cycle -> old responses never appear; first
//     resp_addr=0x40 with word 16.
//  4. req_addr=4*MEM_WORDS (0x1000) -> resp_instr=0x00000013, resp_err=1; stream continues normally.
//  5. req_addr=0x6: with IMEM_ALIGN_CHECK_EN -> NOP, resp_err=1; without -> word 1, resp_err=0.
//  6. Assert rst low with 2 in flight and 1 buffered -> outputs 0 immediately; after release
//     req_ready=1, no stale response emitted; new req 0x0 returns word 0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants, response payload and sizing helpers for the instruction-fetch responder.
// The program image lives in rom_image(); it stands in for the hex file normally loaded at elaboration.
package imem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned INSTR_W   = 32;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
    logic               err;
  } imem_resp_t;

  function automatic int unsigned idx_width(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Word i of the program image holds 0x11*(i+1): 0x11, 0x22, 0x33, 0x44, ...
  function automatic logic [31:0] rom_image(input logic [31:0] idx);
    return 32'h11 * (idx + 32'd1);
  endfunction

endpackage

// File: rtl/imem_resp_fifo.sv
// Response FIFO for the fetch responder: ring buffer with a registered copy of the head entry,
// synchronous clear, and an occupancy count.
module imem_resp_fifo
  import imem_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          push_i,
  input  imem_resp_t    push_data_i,
  input  logic          pop_i,
  output imem_resp_t    head_o,
  output logic          head_valid_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  imem_resp_t    mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  imem_resp_t    head_q, head_d;
  logic          head_vld_q, head_vld_d;
  logic          do_push, do_pop;

  // Pointer/count update and next head value, so the outputs come straight from flops.
  always_comb begin
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    head_d     = '0;
    head_vld_d = 1'b0;
    do_push    = push_i & ~clear_i;
    do_pop     = pop_i & ~clear_i & (cnt_q != '0);
    if (clear_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
      if (do_pop)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
    if (cnt_d != '0) begin
      head_vld_d = 1'b1;
      head_d     = (do_push && (wr_q == rd_d)) ? push_data_i : mem_q[rd_d];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
      if (do_push) mem_q[wr_q] <= push_data_i;
    end
  end

  assign head_o       = head_q;
  assign head_valid_o = head_vld_q;
  assign count_o      = cnt_q;

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: fixed-latency ROM pipeline feeding a credit-limited response FIFO.
// Build option IMEM_ALIGN_CHECK_EN: misaligned PCs return NOP with resp_err set.
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_instr,
  output logic [63:0] resp_addr,
  output logic        resp_err
);

  localparam int unsigned IDX_W = idx_width(MEM_WORDS);
  localparam int unsigned CW    = cnt_width(FIFO_DEPTH);
  localparam int unsigned TW    = CW + 1;

  logic               accept, push, pop;
  logic [IDX_W-1:0]   idx;
  logic               oor, req_err;
  imem_resp_t         req_pl;
  logic [LATENCY-1:0] vld_q, vld_d;
  imem_resp_t         pl_q [LATENCY];
  imem_resp_t         pl_d [LATENCY];
  logic [CW-1:0]      fifo_cnt;
  imem_resp_t         head;
  logic               head_vld;
  logic [TW-1:0]      infl_d, fifo_nxt;
  logic               ready_q, ready_d;

  assign accept = req_valid & ready_q;
  assign push   = vld_q[LATENCY-1] & ~flush;
  assign pop    = head_vld & resp_ready & ~flush;

  // ROM lookup and fault decode for the incoming PC.
  always_comb begin
    idx = req_addr[IDX_W+1:2];
    oor = |req_addr[63:IDX_W+2];
`ifdef IMEM_ALIGN_CHECK_EN
    req_err = oor | (|req_addr[1:0]);
`else
    req_err = oor;
`endif
    req_pl.addr  = req_addr;
    req_pl.err   = req_err;
    req_pl.instr = req_err ? NOP_INSTR : rom_image(32'(idx));
  end

  // Latency pipeline and credit count; a flush keeps only the request accepted alongside it.
  always_comb begin
    vld_d    = '0;
    pl_d     = pl_q;
    vld_d[0] = accept;
    pl_d[0]  = req_pl;
    for (int i = 1; i < int'(LATENCY); i++) begin
      vld_d[i] = vld_q[i-1] & ~flush;
      pl_d[i]  = pl_q[i-1];
    end
    infl_d = '0;
    for (int i = 0; i < int'(LATENCY); i++) infl_d = infl_d + TW'(vld_d[i]);
    fifo_nxt = flush ? '0 : TW'(fifo_cnt) + TW'(push) - TW'(pop);
    ready_d  = (infl_d + fifo_nxt) < TW'(FIFO_DEPTH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q   <= '0;
      ready_q <= 1'b0;
      for (int i = 0; i < int'(LATENCY); i++) pl_q[i] <= '0;
    end else begin
      vld_q   <= vld_d;
      ready_q <= ready_d;
      for (int i = 0; i < int'(LATENCY); i++) pl_q[i] <= pl_d[i];
    end
  end

  imem_resp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (flush),
    .push_i       (push),
    .push_data_i  (pl_q[LATENCY-1]),
    .pop_i        (pop),
    .head_o       (head),
    .head_valid_o (head_vld),
    .count_o      (fifo_cnt)
  );

  assign req_ready  = ready_q;
  assign resp_valid = head_vld;
  assign resp_instr = head.instr;
  assign resp_addr  = head.addr;
  assign resp_err   = head.err;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder with an in-order response scoreboard.
module tb_imem_fetch_responder;
  import imem_pkg::*;

  logic        clk, rst, req_valid, req_ready, flush, resp_valid, resp_ready, resp_err;
  logic [63:0] req_addr, resp_addr;
  logic [31:0] resp_instr;
  logic [31:0] cur_instr;
  logic        cur_err;
  imem_resp_t  sb[$];
  int          total, bad;
  bit          last_acc;
  int          n_acc;
  logic [31:0] t2_exp [0:7];

  imem_fetch_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_instr (resp_instr),
    .resp_addr  (resp_addr),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [63:0] a, input logic [31:0] ins, input logic e);
    req_valid = 1'b1;
    req_addr  = a;
    cur_instr = ins;
    cur_err   = e;
  endtask

  // One clock: sample handshakes at the falling edge, then step past the rising edge.
  task automatic tick();
    imem_resp_t e;
    @(negedge clk);
    last_acc = 1'b0;
    if (flush) begin
      sb.delete();
    end else if (resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_resp", 64'(resp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_addr", resp_addr, e.addr);
        chk("resp_instr", 64'(resp_instr), 64'(e.instr));
        chk("resp_err", 64'(resp_err), 64'(e.err));
      end
    end
    if (req_valid && req_ready) begin
      e.addr  = req_addr;
      e.instr = cur_instr;
      e.err   = cur_err;
      sb.push_back(e);
      last_acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    req_valid = 1'b0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    total = 0; bad = 0; n_acc = 0; last_acc = 1'b0;
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0; resp_ready = 1'b0;
    cur_instr = '0; cur_err = 1'b0;
    t2_exp[0] = 32'h55; t2_exp[1] = 32'h66; t2_exp[2] = 32'h77; t2_exp[3] = 32'h88;
    t2_exp[4] = 32'h99; t2_exp[5] = 32'hAA; t2_exp[6] = 32'hBB; t2_exp[7] = 32'hCC;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_instr", 64'(resp_instr), 64'd0);
    chk("rst_resp_addr", resp_addr, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'd1);

    // Back-to-back fetch of words 0..3, latency and ordering
    resp_ready = 1'b1;
    drive(64'h0, 32'h11, 1'b0);
    tick();
    chk("t1_lat_c1", 64'(resp_valid), 64'd0);
    drive(64'h4, 32'h22, 1'b0);
    tick();
    chk("t1_lat_c2", 64'(resp_valid), 64'd0);
    drive(64'h8, 32'h33, 1'b0);
    tick();
    chk("t1_first_valid", 64'(resp_valid), 64'd1);
    drive(64'hC, 32'h44, 1'b0);
    tick();
    drain(4);

    // Credit limit with a stalled consumer
    resp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(64'h10 + 64'(4 * n_acc), t2_exp[n_acc], 1'b0);
      tick();
      if (last_acc) n_acc++;
    end
    chk("t2_accepted", 64'(n_acc), 64'd4);
    chk("t2_ready_low", 64'(req_ready), 64'd0);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    chk("t2_ready_back", 64'(req_ready), 64'd1);
    drain(8);

    // Flush with redirected request in the same cycle
    resp_ready = 1'b0;
    drive(64'h20, 32'h99, 1'b0);
    tick();
    drive(64'h24, 32'hAA, 1'b0);
    tick();
    drive(64'h28, 32'hBB, 1'b0);
    tick();
    flush = 1'b1;
    drive(64'h40, 32'h121, 1'b0);
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    chk("t3_valid_after_flush", 64'(resp_valid), 64'd0);
    resp_ready = 1'b1;
    drain(8);
    repeat (3) tick();
    chk("t3_no_stale", 64'(resp_valid), 64'd0);

    // Out-of-range addresses interleaved with normal fetches
    drive(64'h1000, 32'h13, 1'b1);
    tick();
    drive(64'h8, 32'h33, 1'b0);
    tick();
    drive(64'hFFFF_FFFF_FFFF_FFFC, 32'h13, 1'b1);
    tick();
    drive(64'hC, 32'h44, 1'b0);
    tick();
    drain(10);

    // Misaligned PC
`ifdef IMEM_ALIGN_CHECK_EN
    drive(64'h6, 32'h13, 1'b1);
`else
    drive(64'h6, 32'h22, 1'b0);
`endif
    tick();
    drive(64'h4, 32'h22, 1'b0);
    tick();
    drain(8);

    // Reset with two requests in flight and one buffered
    resp_ready = 1'b0;
    drive(64'h0, 32'h11, 1'b0);
    tick();
    drive(64'h4, 32'h22, 1'b0);
    tick();
    drive(64'h8, 32'h33, 1'b0);
    tick();
    chk("t6_buffered", 64'(resp_valid), 64'd1);
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(resp_valid), 64'd0);
    chk("t6_rst_instr", 64'(resp_instr), 64'd0);
    chk("t6_rst_addr", resp_addr, 64'd0);
    chk("t6_rst_err", 64'(resp_err), 64'd0);
    chk("t6_rst_ready", 64'(req_ready), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_ready_after", 64'(req_ready), 64'd1);
    resp_ready = 1'b1;
    repeat (4) tick();
    chk("t6_no_stale", 64'(resp_valid), 64'd0);
    drive(64'h0, 32'h11, 1'b0);
    tick();
    drain(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
